// File: rtl/mr_lsu_pkg.sv
// Shared encodings, FSM state type and op metadata for the mr_lsu load/store stage.
// The misaligned-access trap is controlled by MR_LSU_MISALIGN_TRAP_EN.
`ifndef XLEN
`define XLEN 32
`endif

package mr_lsu_pkg;

  localparam int XLEN        = `XLEN;
  localparam int REGSEL_BITS = 5;
  localparam int MEM_OP_BITS = 2;
  localparam int MEM_SZ_BITS = 2;

  localparam logic [MEM_OP_BITS-1:0] MEMOP_NONE  = 2'd0;
  localparam logic [MEM_OP_BITS-1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [MEM_OP_BITS-1:0] MEMOP_STORE = 2'd2;

  localparam logic [MEM_SZ_BITS-1:0] MEM_SZ_B = 2'd0;
  localparam logic [MEM_SZ_BITS-1:0] MEM_SZ_H = 2'd1;
  localparam logic [MEM_SZ_BITS-1:0] MEM_SZ_W = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP
  } e_lsu_state;

  // What a pending load still needs once the bus request has gone out.
  typedef struct packed {
    logic [1:0]             addr_lo;
    logic [REGSEL_BITS-1:0] dest_reg;
    logic [MEM_SZ_BITS-1:0] size;
    logic                   sign_ext;
  } meta_t;

  function automatic logic [MEM_SZ_BITS-1:0] norm_size(input logic [MEM_SZ_BITS-1:0] sz);
    return (sz == MEM_SZ_B || sz == MEM_SZ_H) ? sz : MEM_SZ_W;
  endfunction

  function automatic logic misaligned(input logic [MEM_SZ_BITS-1:0] sz, input logic [1:0] a);
    return ((sz == MEM_SZ_H) && a[0]) || ((sz == MEM_SZ_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mr_lsu_if.sv
// Bundles around mr_lsu: ALU-side op input, data-memory bus, register writeback.
// wb_fault exists only when MR_LSU_MISALIGN_TRAP_EN is defined.
interface mr_lsu_ls_if;
  import mr_lsu_pkg::*;
  logic                   ls_valid;
  logic                   ls_ready;
  logic [XLEN-1:0]        ls_dest;
  logic [REGSEL_BITS-1:0] ls_dest_reg;
  logic [MEM_OP_BITS-1:0] ls_memop;
  logic [MEM_SZ_BITS-1:0] ls_size;
  logic                   ls_signed;
  logic [XLEN-1:0]        ls_payload;

  modport master (output ls_valid, ls_dest, ls_dest_reg, ls_memop, ls_size, ls_signed, ls_payload,
                  input  ls_ready);
  modport slave  (input  ls_valid, ls_dest, ls_dest_reg, ls_memop, ls_size, ls_signed, ls_payload,
                  output ls_ready);
endinterface

interface mr_lsu_dm_if;
  import mr_lsu_pkg::*;
  logic            dm_req_valid;
  logic            dm_req_ready;
  logic [XLEN-1:0] dm_addr;
  logic            dm_we;
  logic [3:0]      dm_be;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_rsp_valid;
  logic [XLEN-1:0] dm_rdata;

  modport master (output dm_req_valid, dm_addr, dm_we, dm_be, dm_wdata,
                  input  dm_req_ready, dm_rsp_valid, dm_rdata);
  modport slave  (input  dm_req_valid, dm_addr, dm_we, dm_be, dm_wdata,
                  output dm_req_ready, dm_rsp_valid, dm_rdata);
endinterface

interface mr_lsu_wb_if;
  import mr_lsu_pkg::*;
  logic                   wb_valid;
  logic [REGSEL_BITS-1:0] wb_reg;
  logic [XLEN-1:0]        wb_data;
`ifdef MR_LSU_MISALIGN_TRAP_EN
  logic                   wb_fault;

  modport master (output wb_valid, wb_reg, wb_data, wb_fault);
  modport slave  (input  wb_valid, wb_reg, wb_data, wb_fault);
`else
  modport master (output wb_valid, wb_reg, wb_data);
  modport slave  (input  wb_valid, wb_reg, wb_data);
`endif
endinterface

// File: rtl/mr_lsu_align.sv
// mr_lsu_align: byte-enable / store-lane replication and load lane extract + extend.
// Latency: combinational. Backpressure: none (pure function of its inputs).
module mr_lsu_align
  import mr_lsu_pkg::*;
(
  input  logic [1:0]             addr_lo_i,
  input  logic [MEM_SZ_BITS-1:0] size_i,
  input  logic                   sign_ext_i,
  input  logic [XLEN-1:0]        st_data_i,
  input  logic [XLEN-1:0]        ld_word_i,
  output logic [3:0]             be_o,
  output logic [XLEN-1:0]        st_word_o,
  output logic [XLEN-1:0]        ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (addr_lo_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    // Halfword lane follows addr[1] only, so a misaligned H lands on the containing half.
    ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  end

  always_comb begin
    be_o      = 4'b1111;
    st_word_o = st_data_i;
    ld_data_o = ld_word_i;
    case (size_i)
      MEM_SZ_B: begin
        be_o      = 4'b0001 << addr_lo_i;
        st_word_o = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sign_ext_i & ld_byte[7]}}, ld_byte};
      end
      MEM_SZ_H: begin
        be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        st_word_o = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sign_ext_i & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mr_lsu.sv
// mr_lsu: load/store stage between ALU and register file; optional trap via MR_LSU_MISALIGN_TRAP_EN.
// Latency: non-mem 1 cycle; load 3 cycles + request stall + response wait; store retires at handshake.
// Backpressure: ls_ready only in IDLE (single outstanding access); writeback is never stalled.
module mr_lsu
  import mr_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  mr_lsu_ls_if.slave  ls,
  mr_lsu_dm_if.master dm,
  mr_lsu_wb_if.master wb
);

  e_lsu_state             state_q, state_d;
  meta_t                  meta_q, meta_d;
  logic                   dm_req_valid_q, dm_req_valid_d;
  logic [XLEN-1:0]        dm_addr_q, dm_addr_d;
  logic                   dm_we_q, dm_we_d;
  logic [3:0]             dm_be_q, dm_be_d;
  logic [XLEN-1:0]        dm_wdata_q, dm_wdata_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [REGSEL_BITS-1:0] wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]        wb_data_q, wb_data_d;
`ifdef MR_LSU_MISALIGN_TRAP_EN
  logic                   wb_fault_q, wb_fault_d;
`endif

  logic                   accept;
  logic                   is_mem;
  logic [MEM_SZ_BITS-1:0] in_size;
  logic                   idle;
  logic [1:0]             al_addr_lo;
  logic [MEM_SZ_BITS-1:0] al_size;
  logic                   al_sign;
  logic [3:0]             al_be;
  logic [XLEN-1:0]        al_st_word;
  logic [XLEN-1:0]        al_ld_data;

  assign idle        = (state_q == LSU_IDLE);
  assign ls.ls_ready = idle;
  assign accept      = ls.ls_valid & idle;
  assign is_mem      = (ls.ls_memop == MEMOP_LOAD) || (ls.ls_memop == MEMOP_STORE);
  assign in_size     = norm_size(ls.ls_size);

  // One aligner serves both directions: incoming op while idle, pending load otherwise.
  assign al_addr_lo = idle ? ls.ls_dest[1:0] : meta_q.addr_lo;
  assign al_size    = idle ? in_size         : meta_q.size;
  assign al_sign    = idle ? ls.ls_signed    : meta_q.sign_ext;

  mr_lsu_align u_align (
    .addr_lo_i  (al_addr_lo),
    .size_i     (al_size),
    .sign_ext_i (al_sign),
    .st_data_i  (ls.ls_payload),
    .ld_word_i  (dm.dm_rdata),
    .be_o       (al_be),
    .st_word_o  (al_st_word),
    .ld_data_o  (al_ld_data)
  );

  always_comb begin
    state_d        = state_q;
    meta_d         = meta_q;
    dm_req_valid_d = dm_req_valid_q;
    dm_addr_d      = dm_addr_q;
    dm_we_d        = dm_we_q;
    dm_be_d        = dm_be_q;
    dm_wdata_d     = dm_wdata_q;
    wb_valid_d     = 1'b0;
    wb_reg_d       = wb_reg_q;
    wb_data_d      = wb_data_q;
`ifdef MR_LSU_MISALIGN_TRAP_EN
    wb_fault_d     = 1'b0;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = (ls.ls_dest_reg != '0);
            wb_reg_d   = ls.ls_dest_reg;
            wb_data_d  = ls.ls_dest;
          end
`ifdef MR_LSU_MISALIGN_TRAP_EN
          else if (misaligned(in_size, ls.ls_dest[1:0])) begin
            wb_fault_d = 1'b1;
          end
`endif
          else begin
            state_d         = LSU_REQ;
            dm_req_valid_d  = 1'b1;
            dm_addr_d       = {ls.ls_dest[XLEN-1:2], 2'b00};
            dm_we_d         = (ls.ls_memop == MEMOP_STORE);
            dm_be_d         = al_be;
            dm_wdata_d      = al_st_word;
            meta_d.addr_lo  = ls.ls_dest[1:0];
            meta_d.dest_reg = ls.ls_dest_reg;
            meta_d.size     = in_size;
            meta_d.sign_ext = ls.ls_signed;
          end
        end
      end
      LSU_REQ: begin
        if (dm.dm_req_ready) begin
          dm_req_valid_d = 1'b0;
          state_d        = dm_we_q ? LSU_IDLE : LSU_RESP;
        end
      end
      LSU_RESP: begin
        if (dm.dm_rsp_valid) begin
          wb_valid_d = (meta_q.dest_reg != '0);
          wb_reg_d   = meta_q.dest_reg;
          wb_data_d  = al_ld_data;
          state_d    = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LSU_IDLE;
      meta_q         <= '0;
      dm_req_valid_q <= 1'b0;
      dm_addr_q      <= '0;
      dm_we_q        <= 1'b0;
      dm_be_q        <= '0;
      dm_wdata_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_q       <= '0;
      wb_data_q      <= '0;
`ifdef MR_LSU_MISALIGN_TRAP_EN
      wb_fault_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      meta_q         <= meta_d;
      dm_req_valid_q <= dm_req_valid_d;
      dm_addr_q      <= dm_addr_d;
      dm_we_q        <= dm_we_d;
      dm_be_q        <= dm_be_d;
      dm_wdata_q     <= dm_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_q       <= wb_reg_d;
      wb_data_q      <= wb_data_d;
`ifdef MR_LSU_MISALIGN_TRAP_EN
      wb_fault_q     <= wb_fault_d;
`endif
    end
  end

  assign dm.dm_req_valid = dm_req_valid_q;
  assign dm.dm_addr      = dm_addr_q;
  assign dm.dm_we        = dm_we_q;
  assign dm.dm_be        = dm_be_q;
  assign dm.dm_wdata     = dm_wdata_q;
  assign wb.wb_valid     = wb_valid_q;
  assign wb.wb_reg       = wb_reg_q;
  assign wb.wb_data      = wb_data_q;
`ifdef MR_LSU_MISALIGN_TRAP_EN
  assign wb.wb_fault     = wb_fault_q;
`endif

endmodule

// File: tb/tb_mr_lsu.sv
// Scoreboard bench for mr_lsu: directed ops push expected bus/writeback records, a monitor pops them.
// Misaligned-trap expectations follow MR_LSU_MISALIGN_TRAP_EN.
module tb_mr_lsu;
  import mr_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mr_lsu_ls_if ls_if ();
  mr_lsu_dm_if dm_if ();
  mr_lsu_wb_if wb_if ();

  mr_lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ls    (ls_if),
    .dm    (dm_if),
    .wb    (wb_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dm_exp_t;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] data;
    int          cyc;
  } wb_exp_t;

  dm_exp_t dm_q[$];
  wb_exp_t wb_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: writebacks and bus handshakes are checked against the queues as they appear.
  logic        pend = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;
  logic [3:0]  p_be;
  always @(negedge clk) begin : mon
    wb_exp_t we_e;
    dm_exp_t de_e;
    if (rst_n) begin
      if (wb_if.wb_valid) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected_valid", {31'b0, wb_if.wb_valid}, 32'd0);
        end else begin
          we_e = wb_q.pop_front();
          chk("wb_reg", {27'b0, wb_if.wb_reg}, {27'b0, we_e.rg});
          chk("wb_data", wb_if.wb_data, we_e.data);
          chk("wb_cycle", cyc, we_e.cyc);
        end
      end
      if (dm_if.dm_req_valid && pend) begin
        chk("dm_addr_stable", dm_if.dm_addr, p_addr);
        chk("dm_we_stable", {31'b0, dm_if.dm_we}, {31'b0, p_we});
        chk("dm_be_stable", {28'b0, dm_if.dm_be}, {28'b0, p_be});
        chk("dm_wdata_stable", dm_if.dm_wdata, p_wdata);
      end
      if (dm_if.dm_req_valid && dm_if.dm_req_ready) begin
        if (dm_q.size() == 0) begin
          chk("dm_unexpected_req", {31'b0, dm_if.dm_req_valid}, 32'd0);
        end else begin
          de_e = dm_q.pop_front();
          chk("dm_addr", dm_if.dm_addr, de_e.addr);
          chk("dm_we", {31'b0, dm_if.dm_we}, {31'b0, de_e.we});
          chk("dm_be", {28'b0, dm_if.dm_be}, {28'b0, de_e.be});
          chk("dm_wdata", dm_if.dm_wdata, de_e.wdata);
        end
      end
      pend    = dm_if.dm_req_valid && !dm_if.dm_req_ready;
      p_addr  = dm_if.dm_addr;
      p_we    = dm_if.dm_we;
      p_be    = dm_if.dm_be;
      p_wdata = dm_if.dm_wdata;
    end else begin
      pend = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dm(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    dm_q.push_back('{addr: a, we: we, be: be, wdata: wd});
  endtask

  task automatic push_wb(input logic [4:0] rg, input logic [31:0] d, input int c);
    wb_q.push_back('{rg: rg, data: d, cyc: c});
  endtask

  // Returns the accept cycle (counter value during the cycle ls_valid & ls_ready held).
  task automatic send_op(input logic [1:0] op, input logic [1:0] sz, input logic sg,
                         input logic [31:0] dest, input logic [4:0] rg, input logic [31:0] pay,
                         output int acc);
    int n;
    n = 0;
    while (!ls_if.ls_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ls_if.ls_ready) chk("ls_ready_timeout", {31'b0, ls_if.ls_ready}, 32'd1);
    ls_if.ls_memop    = op;
    ls_if.ls_size     = sz;
    ls_if.ls_signed   = sg;
    ls_if.ls_dest     = dest;
    ls_if.ls_dest_reg = rg;
    ls_if.ls_payload  = pay;
    ls_if.ls_valid    = 1'b1;
    tick();
    ls_if.ls_valid    = 1'b0;
    acc = cyc - 1;
  endtask

  task automatic mem_serve(input int stall, input bit do_rsp, input int wt, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!dm_if.dm_req_valid && n < 50) begin
      tick();
      n++;
    end
    if (!dm_if.dm_req_valid) begin
      chk("dm_req_timeout", {31'b0, dm_if.dm_req_valid}, 32'd1);
    end else begin
      repeat (stall) tick();
      dm_if.dm_req_ready = 1'b1;
      tick();
      dm_if.dm_req_ready = 1'b0;
      if (do_rsp) begin
        repeat (wt) tick();
        dm_if.dm_rsp_valid = 1'b1;
        dm_if.dm_rdata     = rdata;
        tick();
        dm_if.dm_rsp_valid = 1'b0;
        dm_if.dm_rdata     = '0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ls_ready"}, {31'b0, ls_if.ls_ready}, 32'd1);
    chk({tag, "_dm_req_valid"}, {31'b0, dm_if.dm_req_valid}, 32'd0);
    chk({tag, "_wb_valid"}, {31'b0, wb_if.wb_valid}, 32'd0);
    chk({tag, "_wb_reg"}, {27'b0, wb_if.wb_reg}, 32'd0);
    chk({tag, "_wb_data"}, wb_if.wb_data, 32'd0);
    chk({tag, "_dm_addr"}, dm_if.dm_addr, 32'd0);
    chk({tag, "_dm_we"}, {31'b0, dm_if.dm_we}, 32'd0);
    chk({tag, "_dm_be"}, {28'b0, dm_if.dm_be}, 32'd0);
    chk({tag, "_dm_wdata"}, dm_if.dm_wdata, 32'd0);
`ifdef MR_LSU_MISALIGN_TRAP_EN
    chk({tag, "_wb_fault"}, {31'b0, wb_if.wb_fault}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    ls_if.ls_valid = 1'b0;   ls_if.ls_dest = '0;   ls_if.ls_dest_reg = '0;
    ls_if.ls_memop = '0;     ls_if.ls_size = '0;   ls_if.ls_signed = 1'b0;
    ls_if.ls_payload = '0;
    dm_if.dm_req_ready = 1'b0; dm_if.dm_rsp_valid = 1'b0; dm_if.dm_rdata = '0;

    #2 rst_n = 1'b0;
    tick();
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Three back-to-back non-memory ops to x5.
    ls_if.ls_memop = MEMOP_NONE; ls_if.ls_size = MEM_SZ_W; ls_if.ls_signed = 1'b0;
    ls_if.ls_dest = 32'h1234;    ls_if.ls_dest_reg = 5'd5; ls_if.ls_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ls_ready_b2b", {31'b0, ls_if.ls_ready}, 32'd1);
      tick();
      push_wb(5'd5, 32'h1234, cyc);
    end
    ls_if.ls_valid = 1'b0;
    chk("ls_ready_after_b2b", {31'b0, ls_if.ls_ready}, 32'd1);
    tick();

    // Load B signed from 0x103.
    push_dm(32'h100, 1'b0, 4'b1000, 32'h0);
    send_op(MEMOP_LOAD, MEM_SZ_B, 1'b1, 32'h103, 5'd3, 32'h0, acc);
    push_wb(5'd3, 32'hFFFF_FF80, acc + 3);
    mem_serve(0, 1'b1, 0, 32'h80FF_0000);

    // Load H unsigned from 0x102 with two stall cycles.
    push_dm(32'h100, 1'b0, 4'b1100, 32'h0);
    send_op(MEMOP_LOAD, MEM_SZ_H, 1'b0, 32'h102, 5'd6, 32'h0, acc);
    push_wb(5'd6, 32'h0000_BEEF, acc + 5);
    mem_serve(2, 1'b1, 0, 32'hBEEF_0000);

    // Load to x0: bus access happens, writeback does not.
    push_dm(32'h100, 1'b0, 4'b0011, 32'h0);
    send_op(MEMOP_LOAD, MEM_SZ_H, 1'b1, 32'h100, 5'd0, 32'h0, acc);
    mem_serve(0, 1'b1, 0, 32'h1111_8222);

    // Store B to 0x201.
    push_dm(32'h200, 1'b1, 4'b0010, 32'hABAB_ABAB);
    send_op(MEMOP_STORE, MEM_SZ_B, 1'b0, 32'h201, 5'd9, 32'h0000_00AB, acc);
    chk("ls_ready_in_req", {31'b0, ls_if.ls_ready}, 32'd0);
    mem_serve(0, 1'b0, 0, 32'h0);
    chk("ls_ready_after_store", {31'b0, ls_if.ls_ready}, 32'd1);

    // Store H to 0x202, one stall cycle.
    push_dm(32'h200, 1'b1, 4'b1100, 32'hCDEF_CDEF);
    send_op(MEMOP_STORE, MEM_SZ_H, 1'b0, 32'h202, 5'd9, 32'h1234_CDEF, acc);
    mem_serve(1, 1'b0, 0, 32'h0);

    // Load B unsigned from 0x101, response two cycles late.
    push_dm(32'h100, 1'b0, 4'b0010, 32'h0);
    send_op(MEMOP_LOAD, MEM_SZ_B, 1'b0, 32'h101, 5'd10, 32'h0, acc);
    push_wb(5'd10, 32'h0000_0056, acc + 5);
    mem_serve(0, 1'b1, 2, 32'h1234_5678);

    // Undefined memop encoding behaves as a non-memory op.
    send_op(2'd3, MEM_SZ_W, 1'b0, 32'hDEAD_0001, 5'd12, 32'h0, acc);
    push_wb(5'd12, 32'hDEAD_0001, acc + 1);

    // Undefined size encoding behaves as a word.
    push_dm(32'h304, 1'b0, 4'b1111, 32'h0);
    send_op(MEMOP_LOAD, 2'd3, 1'b1, 32'h304, 5'd8, 32'h0, acc);
    push_wb(5'd8, 32'h8BAD_F00D, acc + 3);
    mem_serve(0, 1'b1, 0, 32'h8BAD_F00D);

    // Misaligned word load at 0x302.
`ifdef MR_LSU_MISALIGN_TRAP_EN
    send_op(MEMOP_LOAD, MEM_SZ_W, 1'b0, 32'h302, 5'd7, 32'h0, acc);
    chk("trap_no_req", {31'b0, dm_if.dm_req_valid}, 32'd0);
    chk("trap_fault_pulse", {31'b0, wb_if.wb_fault}, 32'd1);
    chk("trap_ls_ready", {31'b0, ls_if.ls_ready}, 32'd1);
    tick();
    chk("trap_fault_clear", {31'b0, wb_if.wb_fault}, 32'd0);
    chk("trap_no_req_later", {31'b0, dm_if.dm_req_valid}, 32'd0);
`else
    push_dm(32'h300, 1'b0, 4'b1111, 32'h0);
    send_op(MEMOP_LOAD, MEM_SZ_W, 1'b0, 32'h302, 5'd7, 32'h0, acc);
    push_wb(5'd7, 32'hCAFE_F00D, acc + 3);
    mem_serve(0, 1'b1, 0, 32'hCAFE_F00D);
`endif

    // Reset while waiting for a load response, then a stray response.
    push_dm(32'h400, 1'b0, 4'b1111, 32'h0);
    send_op(MEMOP_LOAD, MEM_SZ_W, 1'b0, 32'h400, 5'd13, 32'h0, acc);
    mem_serve(0, 1'b0, 0, 32'h0);
    chk("resp_state_not_ready", {31'b0, ls_if.ls_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    dm_if.dm_rsp_valid = 1'b1;
    dm_if.dm_rdata     = 32'hFFFF_FFFF;
    tick();
    dm_if.dm_rsp_valid = 1'b0;
    dm_if.dm_rdata     = '0;
    tick();
    check_reset_outputs("stray_rsp");

    repeat (3) tick();
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("dm_queue_drained", dm_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mr_lsu.md
Name: mr_lsu

Overview:
- Load/store stage; consumes the ALU stage's ls_* output interface.
- Non-memory ops: forwards the result to register writeback.
- Loads/stores: issues a single-outstanding request on the data-memory bus. Loads are lane-extracted and sign/zero-extended before writeback.
- Sits between the ALU stage and the register file.

Parameters:
- XLEN, 32, datapath width (the `XLEN define; only 32 supported).
- REGSEL_BITS, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- ls_valid  in  1  op valid from ALU stage
- ls_ready  out  1  stage can accept op
- ls_dest  in  XLEN  result (non-mem) or effective address (mem)
- ls_dest_reg  in  REGSEL_BITS  destination register
- ls_memop  in  MEM_OP_BITS  MEMOP_NONE/LOAD/STORE
- ls_size  in  MEM_SZ_BITS  MEM_SZ_B/H/W
- ls_signed  in  1  sign-extend load
- ls_payload  in  XLEN  store data
- dm_req_valid  out  1  memory request valid
- dm_req_ready  in  1  memory accepts request
- dm_addr  out  XLEN  word-aligned address ({addr[31:2],2'b0})
- dm_we  out  1  1=store
- dm_be  out  4  byte enables
- dm_wdata  out  XLEN  lane-replicated store data
- dm_rsp_valid  in  1  load data valid
- dm_rdata  in  XLEN  load data word
- wb_valid  out  1  register write pulse
- wb_reg  out  REGSEL_BITS  register index
- wb_data  out  XLEN  register data

Behaviour:
- Reset (async assert, sync deassert in clk domain): state=IDLE, dm_req_valid=0, wb_valid=0, wb_reg=0, wb_data=0, dm_addr/dm_we/dm_be/dm_wdata=0.
- FSM states: IDLE, REQ, RESP.
  - ls_ready = (state==IDLE), combinational from state only.
  - Accept = ls_valid & ls_ready.
- IDLE + accept, MEMOP_NONE:
  - Next cycle: wb_valid=(ls_dest_reg!=0), wb_reg=ls_dest_reg, wb_data=ls_dest.
  - Stay IDLE. Back-to-back throughput is 1/cycle.
- IDLE + accept, LOAD/STORE:
  - Register the op, go to REQ.
  - dm_req_valid=1 next cycle; dm_addr/dm_we/dm_be/dm_wdata stable while dm_req_valid && !dm_req_ready.
- Byte enables from addr[1:0]:
  - B: 4'b0001<<a.
  - H: 4'b0011<<{a[1],1'b0}.
  - W: 4'b1111.
- dm_wdata: B replicates byte 4x; H replicates half 2x; W as-is.
- REQ & dm_req_ready:
  - Drop dm_req_valid.
  - Store → IDLE; no writeback.
  - Load → RESP.
- RESP & dm_rsp_valid:
  - Extract lane by addr[1:0]; extend per size/ls_signed (W ignores signed).
  - Next cycle: wb_valid=(reg!=0), then IDLE.
  - dm_rsp_valid is ignored in IDLE/REQ; a response in the same cycle as the request handshake is illegal.
- Load latency, accept→wb_valid: 3 cycles + request stall cycles + response wait cycles.
- wb_valid is a single-cycle pulse; the register file has no backpressure.
- x0 writes are never signalled.
- ls_valid while !ls_ready: op held upstream; no effect here.
- Reset mid-operation: drop any in-flight request; a subsequent dm_rsp_valid is ignored (state IDLE).
- Undefined size/memop encodings are treated as MEMOP_NONE / MEM_SZ_W.

Optional Feature:
- Macro: MR_LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output wb_fault (1 bit, reset 0).
  - H with addr[0]!=0, or W with addr[1:0]!=0, issues no bus request and no writeback.
  - wb_fault pulses 1 cycle after accept; state stays IDLE.
- When undefined:
  - No port.
  - Misaligned H uses lane addr[1]; misaligned W uses addr[1:0] ignored (aligned-down access).

Decomposition:
- Shared package/config.svi: MEMOP_NONE/LOAD/STORE, MEM_SZ_B/H/W, MEM_OP_BITS, MEM_SZ_BITS, new e_lsu_state enum.
- Sub-module mr_lsu_align: combinational be/wdata generation and load extract/extend, reusable by a future fetch/cache.

Test Plan:
- MEMOP_NONE, dest_reg=5, ls_dest=0x1234, three back-to-back → three wb pulses on consecutive cycles, data 0x1234, ls_ready constant 1.
- Load B signed, addr=0x103, rdata=0x80FF_0000 → dm_be=4'b1000, dm_addr=0x100, wb_data=0xFFFF_FF80.
- Load H unsigned, addr=0x102, rdata=0xBEEF_0000, dm_req_ready low 2 cycles → dm_addr stable, wb_data=0x0000_BEEF; load to x0 → no wb_valid.
- Store B, addr=0x201, payload=0xAB → dm_we=1, dm_be=4'b0010, dm_wdata=0xABAB_ABAB, no wb_valid, ls_ready returns after handshake.
- rst_n low during RESP, then stray dm_rsp_valid → no wb_valid, state IDLE, all outputs at reset values.
- MR_LSU_MISALIGN_TRAP_EN: Load W addr=0x302 → no dm_req_valid, wb_fault pulse; undefined → dm_addr=0x300, be=4'b1111.
